// File: rtl/range_filter_pkg.sv
// Shared types and constants for the ultrasonic range filter: FSM encoding,
// sample clamp limit and averaging window geometry.
package range_filter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FIRE   = 2'd1,
    WAIT   = 2'd2,
    UPDATE = 2'd3
  } state_t;

  localparam int          DIST_W    = 12;
  localparam int          SUM_W     = 14;
  localparam int          WIN_DEPTH = 4;
  localparam int          PTR_W     = $clog2(WIN_DEPTH);
  localparam int          FILL_W    = $clog2(WIN_DEPTH + 1);
  localparam logic [DIST_W-1:0] CLAMP_MM = DIST_W'(4000);

  // Out-of-range echoes are pinned to the sensor's usable maximum.
  function automatic logic [DIST_W-1:0] clamp_mm(input logic [DIST_W-1:0] d);
    return (d > CLAMP_MM) ? CLAMP_MM : d;
  endfunction

endpackage

// File: rtl/range_filter_if.sv
// Bundle of control, ranging handshake and result signals of range_filter.
// master drives en/val_in/dist_in/thr_mm; slave is the filter itself.
interface range_filter_if;
  import range_filter_pkg::*;

  logic              en;
  logic              val_in;
  logic [DIST_W-1:0] dist_in;
  logic [DIST_W-1:0] thr_mm;
  logic              start;
  logic [DIST_W-1:0] dist_out;
  logic              dist_vld;
  logic              no_echo;
  logic              near;

  modport master (
    output en, val_in, dist_in, thr_mm,
    input  start, dist_out, dist_vld, no_echo, near
  );

  modport slave (
    input  en, val_in, dist_in, thr_mm,
    output start, dist_out, dist_vld, no_echo, near
  );

endinterface

// File: rtl/range_filter_avg4_window.sv
// Four-entry circular averaging window with running sum and fill count.
// Exposes the post-write average and fullness so the caller can register them.
module avg4_window
  import range_filter_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              wr,
  input  logic              flush,
  input  logic [DIST_W-1:0] sample,
  output logic [DIST_W-1:0] avg_nxt,
  output logic              full_nxt
);

  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(WIN_DEPTH);

  logic [DIST_W-1:0] slot [WIN_DEPTH];
  logic [SUM_W-1:0]  sum;
  logic [SUM_W-1:0]  sum_nxt;
  logic [PTR_W-1:0]  wr_ptr;
  logic [FILL_W-1:0] fill;

  // The evicted entry is always part of sum, so this never underflows.
  assign sum_nxt  = sum - {2'b00, slot[wr_ptr]} + {2'b00, sample};
  assign avg_nxt  = sum_nxt[SUM_W-1:2];
  assign full_nxt = (fill >= FILL_MAX - FILL_W'(1));

  // NOTE: the window entries are reset (and flushed) explicitly because the
  // running sum is only consistent with them if both start from zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < WIN_DEPTH; i++) slot[i] <= '0;
      sum    <= '0;
      wr_ptr <= '0;
      fill   <= '0;
    end else if (flush) begin
      for (int i = 0; i < WIN_DEPTH; i++) slot[i] <= '0;
      sum    <= '0;
      wr_ptr <= '0;
      fill   <= '0;
    end else if (wr) begin
      slot[wr_ptr] <= sample;
      sum          <= sum_nxt;
      wr_ptr       <= wr_ptr + PTR_W'(1);
      fill         <= (fill == FILL_MAX) ? FILL_MAX : fill + FILL_W'(1);
    end
  end

endmodule

// File: rtl/range_filter.sv
// Periodically triggers an ultrasonic measurement, times out missing echoes,
// and publishes a 4-sample moving average with a proximity flag.
module range_filter
  import range_filter_pkg::*;
#(
  parameter int PERIOD_CYC  = 3_000_000,
  parameter int TIMEOUT_CYC = 2_000_000,
  parameter int MISS_MAX    = 3
) (
  input  logic           clk,
  input  logic           rst,
  range_filter_if.slave  bus
);

  localparam int PW = (PERIOD_CYC  > 1) ? $clog2(PERIOD_CYC)  : 1;
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int MW = (MISS_MAX    > 1) ? $clog2(MISS_MAX)    : 1;

  localparam logic [PW-1:0] P_LAST = PW'(PERIOD_CYC - 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [MW-1:0] M_LAST = MW'(MISS_MAX - 1);

  state_t            state;
  state_t            state_nxt;
  logic [PW-1:0]     pcnt;
  logic [TW-1:0]     tcnt;
  logic [MW-1:0]     mcnt;
  logic              en_q;
  logic [DIST_W-1:0] lat;

  logic              fire;
  logic              timeout;
  logic              upd;
  logic              flush;
  logic [DIST_W-1:0] sample;
  logic [DIST_W-1:0] avg_nxt;
  logic              full_nxt;

  logic [DIST_W-1:0] dist_q;
  logic              vld_q;
  logic              near_q;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // A rising en (or the first cycle after reset) fires immediately rather
  // than waiting out a full period.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.en && (pcnt == P_LAST || !en_q)) state_nxt = FIRE;
      FIRE:    state_nxt = WAIT;
      WAIT:    if (bus.val_in)          state_nxt = UPDATE;
               else if (tcnt == T_LAST) state_nxt = IDLE;
      UPDATE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: every combinational output gets a default first so no path through
  // the block leaves it unassigned, which would infer a latch.
  always_comb begin
    fire    = 1'b0;
    timeout = 1'b0;
    upd     = 1'b0;
    case (state)
      FIRE:    fire    = 1'b1;
      WAIT:    timeout = !bus.val_in && (tcnt == T_LAST);
      UPDATE:  upd     = 1'b1;
      default: ;
    endcase
  end

  assign flush = timeout && (mcnt == M_LAST);

  // ---------------------------------------------------------- counters
  // NOTE: all sequential state uses non-blocking assignment so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pcnt <= '0;
      tcnt <= '0;
      mcnt <= '0;
      en_q <= 1'b0;
      lat  <= '0;
    end else begin
      en_q <= bus.en;

      if (state_nxt == FIRE)  pcnt <= '0;
      else if (pcnt != P_LAST) pcnt <= pcnt + PW'(1);

      if (fire)                                  tcnt <= '0;
      else if (state == WAIT && tcnt != T_LAST)  tcnt <= tcnt + TW'(1);

      if (upd)          mcnt <= '0;
      else if (flush)   mcnt <= '0;
      else if (timeout) mcnt <= mcnt + MW'(1);

      if (state == WAIT && bus.val_in) lat <= bus.dist_in;
    end
  end

  // ------------------------------------------------------------ window
  assign sample = clamp_mm(lat);

  avg4_window u_window (
    .clk      (clk),
    .rst      (rst),
    .wr       (upd),
    .flush    (flush),
    .sample   (sample),
    .avg_nxt  (avg_nxt),
    .full_nxt (full_nxt)
  );

  // ------------------------------------------------------------ results
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dist_q <= '0;
      vld_q  <= 1'b0;
      near_q <= 1'b0;
    end else begin
      vld_q <= 1'b0;
      if (flush) begin
        dist_q <= '0;
        near_q <= 1'b0;
      end else if (upd && full_nxt) begin
        dist_q <= avg_nxt;
        vld_q  <= 1'b1;
        near_q <= (avg_nxt < bus.thr_mm);
      end
    end
  end

  assign bus.start    = fire;
  assign bus.no_echo  = timeout;
  assign bus.dist_out = dist_q;
  assign bus.dist_vld = vld_q;
  assign bus.near     = near_q;

endmodule

// File: tb/tb_range_filter.sv
// Directed bench for range_filter with a short period/timeout; expected
// averages and flags are hand-computed from the sample sequences.
module tb_range_filter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  range_filter_if bus ();

  range_filter #(
    .PERIOD_CYC  (100),
    .TIMEOUT_CYC (50),
    .MISS_MAX    (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int start_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_start(output bit found);
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      tick();
      if (bus.start) begin
        found     = 1'b1;
        start_cyc = cyc;
      end
    end
  endtask

  // Called in the FIRE cycle; returns in the cycle after UPDATE.
  task automatic measure_here(input logic [11:0] d);
    tick();
    bus.val_in  = 1'b1;
    bus.dist_in = d;
    tick();
    bus.val_in  = 1'b0;
    tick();
  endtask

  task automatic measure(input logic [11:0] d);
    bit f;
    wait_start(f);
    check("start_seen", f, 1);
    if (f) measure_here(d);
  endtask

  // Returns in the cycle where no_echo is high.
  task automatic miss();
    bit f;
    int lat;
    wait_start(f);
    check("start_seen", f, 1);
    lat = 0;
    for (int k = 1; k <= 80 && lat == 0; k++) begin
      tick();
      if (bus.no_echo) lat = k;
    end
    check("no_echo_lat", lat, 50);
  endtask

  task automatic do_reset();
    bus.val_in = 1'b0;
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic check_out(input string tag, input logic vld, input logic [11:0] d);
    check({tag, "_vld"}, bus.dist_vld, vld);
    check({tag, "_out"}, bus.dist_out, d);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  s [4];
    int  n_st;
    bit  f;

    bus.en      = 1'b1;
    bus.val_in  = 1'b0;
    bus.dist_in = '0;
    bus.thr_mm  = 12'd300;

    // ---- reset state and first fire
    tick();
    tick();
    check("rst_start", bus.start, 0);
    check("rst_out", bus.dist_out, 0);
    check("rst_vld", bus.dist_vld, 0);
    check("rst_no_echo", bus.no_echo, 0);
    check("rst_near", bus.near, 0);
    rst = 1'b1;
    check("start_cyc1", bus.start, 0);
    tick();
    check("start_cyc2", bus.start, 1);
    s[0] = cyc;

    // ---- scenario 1: 1000 x4
    measure_here(12'd1000);
    check_out("s1_m1", 0, 0);
    measure(12'd1000); s[1] = start_cyc;
    check_out("s1_m2", 0, 0);
    measure(12'd1000); s[2] = start_cyc;
    check_out("s1_m3", 0, 0);
    measure(12'd1000); s[3] = start_cyc;
    check_out("s1_m4", 1, 1000);
    check("s1_near", bus.near, 0);
    check("s1_period_a", s[1] - s[0], 100);
    check("s1_period_b", s[3] - s[2], 100);

    // ---- scenario 2: truncating average
    do_reset();
    measure(12'd100);
    measure(12'd200);
    measure(12'd300);
    check_out("s2_m3", 0, 0);
    measure(12'd401);
    check_out("s2_m4", 1, 250);
    check("s2_near_m4", bus.near, 1);
    measure(12'd500);
    check_out("s2_m5", 1, 350);
    check("s2_near_m5", bus.near, 0);

    // ---- scenario 4: clamp and proximity
    do_reset();
    for (int i = 0; i < 4; i++) measure(12'd4095);
    check_out("s4_clamp", 1, 4000);
    for (int i = 0; i < 4; i++) measure(12'd250);
    check_out("s4_250", 1, 250);
    check("s4_near_250", bus.near, 1);
    measure(12'd350);
    check_out("s4_275", 1, 275);
    check("s4_near_275", bus.near, 1);
    measure(12'd350);
    check_out("s4_300", 1, 300);
    check("s4_near_300", bus.near, 0);
    measure(12'd100);
    check_out("s4_262", 1, 262);
    check("s4_near_262", bus.near, 1);

    // ---- scenario 3: three misses flush the window
    miss();
    check("s3_miss1_out", bus.dist_out, 262);
    tick();
    check("s3_no_echo_pulse", bus.no_echo, 0);
    miss();
    check("s3_miss2_near", bus.near, 1);
    miss();
    tick();
    check("s3_flush_out", bus.dist_out, 0);
    check("s3_flush_near", bus.near, 0);
    measure(12'd500);
    check_out("s3_refill", 0, 0);

    // ---- scenario 5: val_in on the timeout cycle, stray val_in
    do_reset();
    for (int i = 0; i < 3; i++) measure(12'd800);
    wait_start(f);
    check("start_seen", f, 1);
    repeat (50) tick();
    bus.val_in  = 1'b1;
    bus.dist_in = 12'd800;
    #1;
    check("s5_no_echo_race", bus.no_echo, 0);
    tick();
    bus.val_in = 1'b0;
    tick();
    check_out("s5_race", 1, 800);
    bus.val_in  = 1'b1;
    bus.dist_in = 12'd0;
    tick();
    bus.val_in = 1'b0;
    tick();
    check_out("s5_stray", 0, 800);
    measure(12'd400);
    check_out("s5_after_stray", 1, 700);

    // ---- scenario 6: reset mid-WAIT
    wait_start(f);
    check("start_seen", f, 1);
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("s6_rst_start", bus.start, 0);
    check("s6_rst_out", bus.dist_out, 0);
    check("s6_rst_vld", bus.dist_vld, 0);
    check("s6_rst_no_echo", bus.no_echo, 0);
    check("s6_rst_near", bus.near, 0);
    tick();
    rst = 1'b1;
    bus.val_in  = 1'b1;
    bus.dist_in = 12'd123;
    tick();
    bus.val_in = 1'b0;
    check("s6_start_cyc2", bus.start, 1);
    measure_here(12'd600);
    check_out("s6_m1", 0, 0);
    for (int i = 0; i < 3; i++) measure(12'd600);
    check_out("s6_m4", 1, 600);

    // ---- scenario 6: en drop mid-WAIT
    wait_start(f);
    check("start_seen", f, 1);
    tick();
    bus.en = 1'b0;
    tick();
    bus.val_in  = 1'b1;
    bus.dist_in = 12'd1000;
    tick();
    bus.val_in = 1'b0;
    tick();
    check_out("s6_en_drop", 1, 700);
    n_st = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (bus.start) n_st++;
    end
    check("s6_no_start_en0", n_st, 0);
    bus.en = 1'b1;
    tick();
    check("s6_en_rise_start", bus.start, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/range_filter.md
RANGE_FILTER -- requirements
Module: range_filter

Interface
REQ-001 Parameter PERIOD_CYC, default 3_000_000, measurement period in clk cycles (60 ms at 50 MHz).
REQ-002 Parameter TIMEOUT_CYC, default 2_000_000, maximum wait for a result after start (40 ms).
REQ-003 Parameter MISS_MAX, default 3, consecutive misses that flush the averaging window.
REQ-004 clk  in  1  system clock, 50 MHz.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 en  in  1  level; enables periodic measurements.
REQ-007 val_in  in  1  one-cycle result strobe from the ultrasonic ranging block.
REQ-008 dist_in  in  12  measured distance in mm, sampled only when val_in=1.
REQ-009 thr_mm  in  12  proximity threshold in mm, quasi-static.
REQ-010 start  out  1  one-cycle pulse that requests a measurement from the ranging block.
REQ-011 dist_out  out  12  4-sample moving average in mm.
REQ-012 dist_vld  out  1  one-cycle strobe; dist_out updated.
REQ-013 no_echo  out  1  one-cycle strobe; measurement timed out.
REQ-014 near  out  1  level; dist_out < thr_mm and window full.

Function
REQ-015 FSM states are IDLE, FIRE, WAIT and UPDATE; encoding is shared via package.
REQ-016 Period counter: it reloads to 0 on entering FIRE, increments every cycle otherwise, and saturates at PERIOD_CYC-1.
REQ-017 IDLE->FIRE when en=1 and the period counter is at PERIOD_CYC-1; the first FIRE after reset or after en rises occurs on the next cycle.
REQ-018 FIRE: start=1 for exactly one cycle, the timeout counter is cleared, then WAIT.
REQ-019 WAIT->UPDATE on val_in=1, with dist_in latched.
REQ-020 WAIT->IDLE when the timeout counter reaches TIMEOUT_CYC-1; no_echo=1 in that transition cycle and the miss counter increments.
REQ-021 val_in and timeout in the same cycle: val_in wins; no_echo stays 0.
REQ-022 val_in outside WAIT is ignored, with no state or data change.
REQ-023 en deasserted during FIRE, WAIT or UPDATE: the current measurement completes normally, and no new FIRE follows while en=0.
REQ-024 UPDATE (one cycle), sample clamp: s = min(dist_in, 4000).
REQ-025 UPDATE, window update: s is written to a 4-entry circular buffer at wr_ptr, the 14-bit running sum becomes sum - buf[wr_ptr] + s, wr_ptr wraps 3->0, fill count saturates at 4, the miss counter clears, then IDLE.
REQ-026 dist_out = sum[13:2] (truncating divide by 4), registered; dist_vld=1 one cycle after UPDATE, only when fill count = 4 after the update.
REQ-027 While fill count < 4, no dist_vld is produced and dist_out holds its previous value.
REQ-028 Miss counter reaching MISS_MAX flushes the window: buffer entries, sum and fill count go to 0, dist_out goes to 0, near goes to 0, and the miss counter goes to 0.
REQ-029 near is registered, recomputed with every dist_vld, and cleared on flush.

Reset
REQ-030 On rst=0 all of the following clear asynchronously to their values: state=IDLE, all counters=0, buffer=0, sum=0, wr_ptr=0, start=0, dist_out=0, dist_vld=0, no_echo=0, near=0.
REQ-031 Reset mid-WAIT abandons the measurement; a val_in arriving after reset release, outside WAIT, is ignored.
REQ-032 After reset release with en=1, start asserts on cycle 2 (IDLE, then FIRE).

Structure
REQ-033 Shared package holds the FSM state enum, the clamp constant 4000, and the window depth 4.
REQ-034 One sub-module, avg4_window, holds the circular buffer, running sum, fill count and flush input.

Verification
REQ-035 Scenario 1: PERIOD_CYC=100, TIMEOUT_CYC=50, en=1; val_in returns 1000, 1000, 1000, 1000 -> first dist_vld on the 4th, dist_out=1000, start pulses exactly 100 cycles apart.
REQ-036 Scenario 2: samples 100, 200, 300, 401 -> dist_out=250 (truncated); 5th sample 500 -> dist_out=350.
REQ-037 Scenario 3: no val_in after start -> no_echo at cycle 50 after FIRE; three misses in a row -> flush, dist_out=0, near=0.
REQ-038 Scenario 4: dist_in=4095 x4 -> dist_out=4000; thr_mm=300 with samples 250 x4 -> near=1, then samples 350 x4 -> near=0 on the dist_vld where the average reaches >=300.
REQ-039 Scenario 5: val_in in the same cycle as timeout -> UPDATE taken, no_echo=0; stray val_in in IDLE -> no effect.
REQ-040 Scenario 6: rst pulse mid-WAIT, and en drop mid-WAIT -> all outputs are 0 after reset; with en=0 the pending result is consumed and no further start pulses occur.
